// File: rtl/elv_car_scheduler.sv
// SCAN elevator car scheduler: latches calls, times floor travel, drives the motor direction and door status.
// Optional ELV_DOOR_HOLD_EN: door_hold keeps the door timer at 0 while the door is open.
module elv_car_scheduler #(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 3840000,
    parameter int DOOR_CYCLES   = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  estop,
    input  logic                  door_hold,
    output logic [1:0]            elv1_dir,
    output logic [3:0]            cur_floor,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [1:0] DIR_UP   = 2'd0;
    localparam logic [1:0] DIR_DOWN = 2'd1;
    localparam logic [1:0] DIR_STOP = 2'd2;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t                  state_reg;
    logic [1:0]              dir_reg;
    logic [3:0]              floor_reg;
    logic                    door_open_reg;
    logic [NUM_FLOORS-1:0]   pending_reg;
    logic [TW-1:0]           travel_reg;
    logic [DW-1:0]           door_reg;
    logic                    last_up_reg;

    // Constant per-floor masks: floors strictly above, strictly below, and the floor itself.
    logic [NUM_FLOORS-1:0] above_mask [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] below_mask [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] floor_bit  [NUM_FLOORS];

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            for (genvar gj = 0; gj < NUM_FLOORS; gj++) begin : g_bit
                assign above_mask[gi][gj] = (gj > gi);
                assign below_mask[gi][gj] = (gj < gi);
                assign floor_bit[gi][gj]  = (gj == gi);
            end
        end
    endgenerate

    logic [FW-1:0]         cur_idx;
    logic [FW-1:0]         up_idx;
    logic [FW-1:0]         dn_idx;
    logic [NUM_FLOORS-1:0] cur_bit;
    logic [NUM_FLOORS-1:0] up_bit;
    logic [NUM_FLOORS-1:0] dn_bit;
    logic [NUM_FLOORS-1:0] set_vec;
    logic [NUM_FLOORS-1:0] pend_now;
    logic                  req_here;
    logic                  req_above;
    logic                  req_below;
    logic                  arrive_up;
    logic                  arrive_dn;
    logic                  beyond_up;
    logic                  beyond_dn;
    logic                  door_call;
    logic                  hold_now;
    logic                  travel_done;
    logic                  door_done;

    assign cur_idx = floor_reg[FW-1:0];
    assign up_idx  = cur_idx + FW'(1);
    assign dn_idx  = cur_idx - FW'(1);
    assign cur_bit = floor_bit[cur_idx];
    assign up_bit  = floor_bit[up_idx];
    assign dn_bit  = floor_bit[dn_idx];

    // A call for the floor whose door is open reloads the door timer instead of latching.
    assign set_vec  = call_btn & ~((state_reg == DOOR) ? cur_bit : '0);
    assign pend_now = pending_reg | set_vec;

    assign req_here  = |(pending_reg & cur_bit);
    assign req_above = |(pending_reg & above_mask[cur_idx]);
    assign req_below = |(pending_reg & below_mask[cur_idx]);
    assign arrive_up = |(pending_reg & up_bit);
    assign arrive_dn = |(pending_reg & dn_bit);
    assign beyond_up = |(pending_reg & above_mask[cur_idx] & ~up_bit);
    assign beyond_dn = |(pending_reg & below_mask[cur_idx] & ~dn_bit);
    assign door_call = |(call_btn & cur_bit);

    assign travel_done = (travel_reg == TRAVEL_LAST);
    assign door_done   = (door_reg == DOOR_LAST);

`ifdef ELV_DOOR_HOLD_EN
    assign hold_now = door_hold;
`else
    assign hold_now = door_hold & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dir_reg       <= DIR_STOP;
            floor_reg     <= 4'd0;
            door_open_reg <= 1'b0;
            pending_reg   <= '0;
            travel_reg    <= '0;
            door_reg      <= '0;
            last_up_reg   <= 1'b1;
        end else begin
            pending_reg   <= pend_now;
            door_open_reg <= (state_reg == DOOR);
            if (estop)
                dir_reg <= DIR_STOP;
            else if (state_reg == MOVE_UP)
                dir_reg <= DIR_UP;
            else if (state_reg == MOVE_DOWN)
                dir_reg <= DIR_DOWN;
            else
                dir_reg <= DIR_STOP;

            // Emergency stop freezes everything except call latching.
            if (!estop) begin
                case (state_reg)
                    IDLE: begin
                        if (req_here) begin
                            state_reg   <= DOOR;
                            door_reg    <= '0;
                            pending_reg <= pend_now & ~cur_bit;
                        end else if (last_up_reg && req_above) begin
                            state_reg  <= MOVE_UP;
                            travel_reg <= '0;
                        end else if (!last_up_reg && req_below) begin
                            state_reg  <= MOVE_DOWN;
                            travel_reg <= '0;
                        end else if (req_below) begin
                            state_reg   <= MOVE_DOWN;
                            travel_reg  <= '0;
                            last_up_reg <= 1'b0;
                        end else if (req_above) begin
                            state_reg   <= MOVE_UP;
                            travel_reg  <= '0;
                            last_up_reg <= 1'b1;
                        end
                    end
                    MOVE_UP: begin
                        if (travel_done) begin
                            travel_reg <= '0;
                            floor_reg  <= floor_reg + 4'd1;
                            if (arrive_up) begin
                                state_reg   <= DOOR;
                                door_reg    <= '0;
                                pending_reg <= pend_now & ~up_bit;
                            end else if (!beyond_up) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            travel_reg <= travel_reg + TW'(1);
                        end
                    end
                    MOVE_DOWN: begin
                        if (travel_done) begin
                            travel_reg <= '0;
                            floor_reg  <= floor_reg - 4'd1;
                            if (arrive_dn) begin
                                state_reg   <= DOOR;
                                door_reg    <= '0;
                                pending_reg <= pend_now & ~dn_bit;
                            end else if (!beyond_dn) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            travel_reg <= travel_reg + TW'(1);
                        end
                    end
                    DOOR: begin
                        if (door_call || hold_now) begin
                            door_reg <= '0;
                        end else if (door_done) begin
                            state_reg <= IDLE;
                            door_reg  <= '0;
                        end else begin
                            door_reg <= door_reg + DW'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign elv1_dir  = dir_reg;
    assign cur_floor = floor_reg;
    assign door_open = door_open_reg;
    assign pending   = pending_reg;

endmodule

// File: tb/tb_elv_car_scheduler.sv
// Directed bench for elv_car_scheduler with 4 floors, 10-cycle travel and 5-cycle door time.
module tb_elv_car_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] call_btn;
    logic       estop;
    logic       door_hold;
    logic [1:0] elv1_dir;
    logic [3:0] cur_floor;
    logic       door_open;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    elv_car_scheduler #(
        .NUM_FLOORS   (4),
        .TRAVEL_CYCLES(10),
        .DOOR_CYCLES  (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .call_btn (call_btn),
        .estop    (estop),
        .door_hold(door_hold),
        .elv1_dir (elv1_dir),
        .cur_floor(cur_floor),
        .door_open(door_open),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        call_btn  = 4'b0000;
        estop     = 1'b0;
        door_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (elv1_dir !== 2'd2)  begin errors++; $display("FAIL reset_dir got %0d want 2", elv1_dir); end
        checks++; if (cur_floor !== 4'd0) begin errors++; $display("FAIL reset_floor got %0d want 0", cur_floor); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door got %0b want 0", door_open); end
        checks++; if (pending !== 4'b0)   begin errors++; $display("FAIL reset_pending got %b want 0000", pending); end
        // Travel to floor 1 and beyond, then assert reset without a clock edge.
        call_btn = 4'b1000;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) call_btn = 4'b0000;
        end
        checks++; if (cur_floor !== 4'd1) begin errors++; $display("FAIL midtravel_floor got %0d want 1", cur_floor); end
        checks++; if (elv1_dir !== 2'd0)  begin errors++; $display("FAIL midtravel_dir got %0d want 0", elv1_dir); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (elv1_dir !== 2'd2)  begin errors++; $display("FAIL async_rst_dir got %0d want 2", elv1_dir); end
        checks++; if (cur_floor !== 4'd0) begin errors++; $display("FAIL async_rst_floor got %0d want 0", cur_floor); end
        checks++; if (pending !== 4'b0)   begin errors++; $display("FAIL async_rst_pending got %b want 0000", pending); end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_travel_up;
        logic [1:0] e_dir;
        logic [3:0] e_floor;
        logic       e_door;
        logic [3:0] e_pend;
        do_reset();
        call_btn = 4'b1000;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) call_btn = 4'b0000;
            e_dir   = (c <= 2) ? 2'd2 : (c <= 32) ? 2'd0 : 2'd2;
            e_floor = (c < 12) ? 4'd0 : (c < 22) ? 4'd1 : (c < 32) ? 4'd2 : 4'd3;
            e_door  = (c >= 33 && c <= 37);
            e_pend  = (c < 32) ? 4'b1000 : 4'b0000;
            checks++; if (elv1_dir !== e_dir)    begin errors++; $display("FAIL up_dir c=%0d got %0d want %0d", c, elv1_dir, e_dir); end
            checks++; if (cur_floor !== e_floor) begin errors++; $display("FAIL up_floor c=%0d got %0d want %0d", c, cur_floor, e_floor); end
            checks++; if (door_open !== e_door)  begin errors++; $display("FAIL up_door c=%0d got %0b want %0b", c, door_open, e_door); end
            checks++; if (pending !== e_pend)    begin errors++; $display("FAIL up_pending c=%0d got %b want %b", c, pending, e_pend); end
        end
        $display("test_travel_up done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_two_stops;
        logic [1:0] e_dir;
        logic [3:0] e_floor;
        logic       e_door;
        do_reset();
        call_btn = 4'b0110;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (c == 1) call_btn = 4'b0000;
            e_dir   = (c <= 2) ? 2'd2 : (c <= 12) ? 2'd0 : (c <= 18) ? 2'd2 : (c <= 28) ? 2'd0 : 2'd2;
            e_floor = (c < 12) ? 4'd0 : (c < 28) ? 4'd1 : 4'd2;
            e_door  = (c >= 13 && c <= 17) || (c >= 29 && c <= 33);
            checks++; if (elv1_dir !== e_dir)    begin errors++; $display("FAIL two_dir c=%0d got %0d want %0d", c, elv1_dir, e_dir); end
            checks++; if (cur_floor !== e_floor) begin errors++; $display("FAIL two_floor c=%0d got %0d want %0d", c, cur_floor, e_floor); end
            checks++; if (door_open !== e_door)  begin errors++; $display("FAIL two_door c=%0d got %0b want %0b", c, door_open, e_door); end
            if (c == 12) begin
                checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL two_pend1 got %b want 0100", pending); end
            end
            if (c == 28) begin
                checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL two_pend2 got %b want 0000", pending); end
            end
        end
        $display("test_two_stops done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reverse;
        logic [1:0] e_dir;
        logic [3:0] e_floor;
        do_reset();
        call_btn = 4'b1010;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 1)  call_btn = 4'b0000;
            if (c == 20) call_btn = 4'b0001;
            if (c == 21) call_btn = 4'b0000;
            e_dir   = (c <= 2) ? 2'd2 : (c <= 12) ? 2'd0 : (c <= 18) ? 2'd2 : (c <= 38) ? 2'd0 :
                      (c <= 44) ? 2'd2 : (c <= 74) ? 2'd1 : 2'd2;
            e_floor = (c < 12) ? 4'd0 : (c < 28) ? 4'd1 : (c < 38) ? 4'd2 : (c < 54) ? 4'd3 :
                      (c < 64) ? 4'd2 : (c < 74) ? 4'd1 : 4'd0;
            checks++; if (elv1_dir !== e_dir)    begin errors++; $display("FAIL rev_dir c=%0d got %0d want %0d", c, elv1_dir, e_dir); end
            checks++; if (cur_floor !== e_floor) begin errors++; $display("FAIL rev_floor c=%0d got %0d want %0d", c, cur_floor, e_floor); end
            if (c == 21) begin
                checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL rev_pend21 got %b want 1001", pending); end
            end
            if (c == 38) begin
                checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL rev_pend38 got %b want 0001", pending); end
            end
            if (c == 75) begin
                checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rev_pend75 got %b want 0000", pending); end
                checks++; if (door_open !== 1'b1)  begin errors++; $display("FAIL rev_door75 got %0b want 1", door_open); end
            end
        end
        $display("test_reverse done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_estop;
        logic [1:0] e_dir;
        logic [3:0] e_floor;
        do_reset();
        call_btn = 4'b0010;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 1)  call_btn = 4'b0000;
            if (c == 5)  estop = 1'b1;
            if (c == 8)  call_btn = 4'b1000;
            if (c == 9)  call_btn = 4'b0000;
            if (c == 12) estop = 1'b0;
            e_dir   = (c <= 2) ? 2'd2 : (c <= 5) ? 2'd0 : (c <= 12) ? 2'd2 : (c <= 19) ? 2'd0 : 2'd2;
            e_floor = (c < 19) ? 4'd0 : 4'd1;
            checks++; if (elv1_dir !== e_dir)    begin errors++; $display("FAIL estop_dir c=%0d got %0d want %0d", c, elv1_dir, e_dir); end
            checks++; if (cur_floor !== e_floor) begin errors++; $display("FAIL estop_floor c=%0d got %0d want %0d", c, cur_floor, e_floor); end
            if (c == 9) begin
                checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL estop_latch got %b want 1010", pending); end
            end
            if (c == 20) begin
                checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL estop_after got %b want 1000", pending); end
                checks++; if (door_open !== 1'b1)  begin errors++; $display("FAIL estop_door got %0b want 1", door_open); end
            end
        end
        $display("test_estop done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_door_reload;
        logic e_door;
        do_reset();
        call_btn = 4'b0100;
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 1)  call_btn = 4'b0000;
            if (c == 25) call_btn = 4'b0100;
            if (c == 26) call_btn = 4'b0000;
            if (c >= 22) begin
                e_door = (c >= 23 && c <= 31);
                checks++; if (door_open !== e_door) begin errors++; $display("FAIL reload_door c=%0d got %0b want %0b", c, door_open, e_door); end
                checks++; if (pending !== 4'b0000)  begin errors++; $display("FAIL reload_pend c=%0d got %b want 0000", c, pending); end
                checks++; if (cur_floor !== 4'd2)   begin errors++; $display("FAIL reload_floor c=%0d got %0d want 2", c, cur_floor); end
            end
        end
        $display("test_door_reload done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_door_hold;
        logic e_door;
        do_reset();
        call_btn = 4'b0001;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 1)  call_btn = 4'b0000;
            if (c == 3)  door_hold = 1'b1;
            if (c == 23) door_hold = 1'b0;
`ifdef ELV_DOOR_HOLD_EN
            e_door = (c >= 3 && c <= 28);
`else
            e_door = (c >= 3 && c <= 7);
`endif
            checks++; if (door_open !== e_door) begin errors++; $display("FAIL hold_door c=%0d got %0b want %0b", c, door_open, e_door); end
            checks++; if (elv1_dir !== 2'd2)    begin errors++; $display("FAIL hold_dir c=%0d got %0d want 2", c, elv1_dir); end
            if (c >= 2) begin
                checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL hold_pend c=%0d got %b want 0000", c, pending); end
            end
        end
        $display("test_door_hold done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst_n     = 1'b0;
        call_btn  = 4'b0000;
        estop     = 1'b0;
        door_hold = 1'b0;
        test_reset();
        test_travel_up();
        test_two_stops();
        test_reverse();
        test_estop();
        test_door_reload();
        test_door_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
